tcb_arb_2mp: RTL
================

TCB_ARB_2MP -- requirements
Module: tcb_arb_2mp

Interface
REQ-001 Parameter AW, default 32, address width; SHALL match all attached tcb_if instances.
REQ-002 Parameter DW, default 32, data width; SHALL match all attached tcb_if instances.
REQ-003 Parameter DLY, default 1, response delay in cycles (0..4); SHALL equal the DLY of every attached interface.
REQ-004 Parameter RR, default 1; 1 selects round-robin arbitration, 0 selects fixed priority with sub0 highest.
REQ-005 Port clk, input, 1, single clock for all logic.
REQ-006 Port rst, input, 1; reset is asynchronous and active-low.
REQ-007 Port sub0, tcb_if.sub, AW/DW, manager 0 connects here (instruction fetch).
REQ-008 Port sub1, tcb_if.sub, AW/DW, manager 1 connects here (load/store).
REQ-009 Port man, tcb_if.man, AW/DW, drives the downstream address decoder.
REQ-010 Elaboration SHALL $error on any DW, BW, AW or DLY mismatch between ports.

Function
REQ-011 Grant SHALL be combinational; it is one-hot or zero, and is zero only when no subN.vld is asserted.
REQ-012 Exactly one subN.vld asserted: that port SHALL be granted.
REQ-013 Both asserted, RR=0: sub0 SHALL be granted.
REQ-014 Both asserted, RR=1: the port not recorded in register last (last granted) SHALL be granted.
REQ-015 last SHALL update to the granted index only on man.trn (man.vld & man.rdy).
REQ-016 Lock register hold SHALL set on man.vld & ~man.rdy and clear on man.trn.
REQ-017 While hold is set, the grant SHALL stay frozen on the stalled port, regardless of the other port or priority.
REQ-018 man.vld SHALL equal sub0.vld | sub1.vld.
REQ-019 man.wen/ben/adr/wdt SHALL come from the granted port, or from sub0 when idle.
REQ-020 subN.rdy SHALL equal man.rdy & gnt[N]; the non-granted port sees rdy=0.
REQ-021 Response tracking SHALL use a DLY-deep shift register of {trn, idx}, shifted every cycle, with stage 0 loaded from man.trn and the grant index.
REQ-022 man.rdt SHALL be broadcast to both subN.rdt.
REQ-023 subN.err SHALL equal man.err only when the last stage is valid with idx==N; otherwise it is 0.
REQ-024 DLY=0: no shift register; err SHALL be routed with the current grant combinationally.
REQ-025 Back-to-back transfers on alternating ports SHALL run at one per cycle with no bubble.
REQ-026 Simultaneous man.trn and the last-stage response to the other port SHALL both be handled in the same cycle.

Reset
REQ-027 On rst low, last SHALL reset to 1 (sub0 wins first contention), hold to 0, and all shift-register valid bits to 0.
REQ-028 Combinational outputs SHALL follow their inputs during reset; subN.err SHALL be 0.
REQ-029 Reset mid-operation SHALL discard pending response tracking; no err is routed after release.

Structure
REQ-030 Shared package tcb_pkg SHALL hold the response-tracking entry typedef and the DLY maximum constant.
REQ-031 A sub-module tcb_arb_sel (priority/round-robin plus hold lock) SHALL be instantiated; the response shift register stays inline.

Verification
REQ-032 Only sub1 vld, adr=0x100, rdy=1, DLY=1 -> man.adr=0x100, sub1.rdy=1, sub0.rdy=0, sub1.err=man.err next cycle.
REQ-033 RR=1, both vld continuously, rdy=1 for 4 cycles after reset -> grant order 0,1,0,1.
REQ-034 RR=0, both vld, rdy=1 for 3 cycles -> sub0 granted all 3 cycles, sub1.rdy=0.
REQ-035 sub1 granted, man.rdy=0 for 3 cycles, sub0 vld asserts in cycle 2 -> grant stays sub1 until rdy=1, then sub0 is granted.
REQ-036 DLY=2, trn sub0 then sub1, man.err=1 on both responses -> sub0.err high 2 cycles after the first trn, sub1.err high the next cycle.
REQ-037 rst low one cycle after a sub0 trn (DLY=1), man.err=1 -> sub0.err stays 0, last=1 after release.

Source files
------------

// File: rtl/tcb_pkg.sv
// Shared TCB definitions: response-tracking entry, delay limit, grant helper.
package tcb_pkg;

    // Largest supported response delay in cycles.
    localparam int unsigned DLY_MAX = 4;

    // One response-tracking entry: a transfer happened, and on which port.
    typedef struct packed {
        logic trn;
        logic idx;
    } tcb_rsp_t;

    // Two-port one-hot grant vector from a port index.
    function automatic logic [1:0] tcb_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/tcb_if.sv
// TCB bus bundle: request (vld/wen/ben/adr/wdt), handshake (rdy), delayed response (rdt/err).
interface tcb_if #(
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned DLY = 1,
    parameter int unsigned BW  = DW / 8
) ();

    logic          vld;
    logic          wen;
    logic [BW-1:0] ben;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdt;
    logic          rdy;
    logic [DW-1:0] rdt;
    logic          err;

    modport man (
        output vld, wen, ben, adr, wdt,
        input  rdy, rdt, err
    );

    modport sub (
        input  vld, wen, ben, adr, wdt,
        output rdy, rdt, err
    );

endinterface

// File: rtl/tcb_arb_sel.sv
// Two-port grant selector: fixed priority or round-robin, with a lock that
// keeps the grant on a stalled port until its transfer completes.
module tcb_arb_sel
    import tcb_pkg::*;
#(
    parameter int unsigned RR = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] vld,
    input  logic       rdy,
    output logic [1:0] gnt,
    output logic       idx
);

    logic last;
    logic hold;
    logic lck;
    logic any;
    logic trn;

    assign any = |vld;
    assign trn = any & rdy;

    // Choose the granted index; a held lock overrides the arbitration.
    always_comb begin
        idx = 1'b0;
        if (hold) begin
            idx = lck;
        end else begin
            case (vld)
                2'b01:   idx = 1'b0;
                2'b10:   idx = 1'b1;
                2'b11:   idx = (RR != 0) ? ~last : 1'b0;
                default: idx = 1'b0;
            endcase
        end
        gnt = any ? tcb_onehot(idx) : 2'b00;
    end

    // Track the last completed grant and lock onto a stalled request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last <= 1'b1;
            hold <= 1'b0;
            lck  <= 1'b0;
        end else begin
            if (trn) begin
                last <= idx;
                hold <= 1'b0;
            end else if (any) begin
                hold <= 1'b1;
                lck  <= idx;
            end
        end
    end

endmodule

// File: rtl/tcb_arb_2mp.sv
// Two-manager TCB arbiter: merges sub0/sub1 onto one manager port and routes
// delayed error responses back to the port that issued each transfer.
module tcb_arb_2mp
    import tcb_pkg::*;
#(
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned DLY = 1,
    parameter int unsigned RR  = 1
) (
    input logic clk,
    input logic rst,
    tcb_if.sub  sub0,
    tcb_if.sub  sub1,
    tcb_if.man  man
);

    if (sub0.AW != AW || sub1.AW != AW || man.AW != AW) begin : g_chk_aw
        $error("tcb_arb_2mp: AW mismatch between ports");
    end
    if (sub0.DW != DW || sub1.DW != DW || man.DW != DW) begin : g_chk_dw
        $error("tcb_arb_2mp: DW mismatch between ports");
    end
    if (sub0.BW != man.BW || sub1.BW != man.BW) begin : g_chk_bw
        $error("tcb_arb_2mp: BW mismatch between ports");
    end
    if (sub0.DLY != DLY || sub1.DLY != DLY || man.DLY != DLY) begin : g_chk_dly
        $error("tcb_arb_2mp: DLY mismatch between ports");
    end
    if (DLY > DLY_MAX) begin : g_chk_dly_max
        $error("tcb_arb_2mp: DLY exceeds DLY_MAX");
    end

    logic [1:0] gnt;
    logic       idx;
    logic       trn;

    tcb_arb_sel #(
        .RR (RR)
    ) u_sel (
        .clk (clk),
        .rst (rst),
        .vld ({sub1.vld, sub0.vld}),
        .rdy (man.rdy),
        .gnt (gnt),
        .idx (idx)
    );

    assign trn = man.vld & man.rdy;

    // Request path: idx is 0 when idle, so sub0 drives the bus then.
    assign man.vld = sub0.vld | sub1.vld;
    assign man.wen = idx ? sub1.wen : sub0.wen;
    assign man.ben = idx ? sub1.ben : sub0.ben;
    assign man.adr = idx ? sub1.adr : sub0.adr;
    assign man.wdt = idx ? sub1.wdt : sub0.wdt;

    assign sub0.rdy = man.rdy & gnt[0];
    assign sub1.rdy = man.rdy & gnt[1];

    assign sub0.rdt = man.rdt;
    assign sub1.rdt = man.rdt;

    if (DLY == 0) begin : g_rsp_comb
        assign sub0.err = rst & man.err & gnt[0];
        assign sub1.err = rst & man.err & gnt[1];
    end else begin : g_rsp_pipe
        tcb_rsp_t pipe [DLY];

        // Shift {trn, idx} every cycle so the last stage lines up with man.err.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int unsigned i = 0; i < DLY; i++) begin
                    pipe[i] <= '0;
                end
            end else begin
                pipe[0] <= '{trn: trn, idx: idx};
                for (int unsigned i = 1; i < DLY; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end

        assign sub0.err = man.err & pipe[DLY-1].trn & ~pipe[DLY-1].idx;
        assign sub1.err = man.err & pipe[DLY-1].trn &  pipe[DLY-1].idx;
    end

endmodule
